// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: alternates between a no-mole gap and a visible mole,
// choosing each mole position from an 8-bit LFSR so that the same position
// is never shown twice in a row. All outputs are registered.
module mole_spawner #(
  parameter logic [31:0] UP_CYCLES  = 32'd50_000_000,
  parameter logic [31:0] GAP_CYCLES = 32'd25_000_000,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       key_esc,
  input  logic       key_space,
  input  logic       hit,
  output logic [2:0] mole_pos,
  output logic       mole_valid,
  output logic       miss_pulse,
  output logic [7:0] round_count
);

  // state | meaning
  // GAP   | no mole shown, counting down the inter-round gap
  // UP    | mole shown, waiting for a hit or for the visible time to expire
  typedef enum logic {
    GAP = 1'b0,
    UP  = 1'b1
  } state_t;

  localparam logic [31:0] UP_LAST  = UP_CYCLES - 32'd1;
  localparam logic [31:0] GAP_LAST = GAP_CYCLES - 32'd1;
  localparam logic [2:0]  CODE_NONE = 3'b000;

  state_t      state, state_nxt;
  logic [31:0] count, count_nxt;
  logic [7:0]  lfsr, lfsr_nxt;
  logic        lfsr_fb;
  logic [2:0]  prev_code, prev_code_nxt;
  logic [2:0]  pos_nxt;
  logic        valid_nxt;
  logic        miss_nxt;
  logic [7:0]  round_nxt;
  logic [2:0]  spawn_code;

  // Position table: index 0..4 -> A, W, D, X, S.
  function automatic logic [2:0] code_at(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b010;
      3'd1:    code = 3'b001;
      3'd2:    code = 3'b100;
      3'd3:    code = 3'b101;
      default: code = 3'b011;
    endcase
    return code;
  endfunction

  // Pick a code from the LFSR value, stepping to the next table entry when the
  // draw would repeat the previous mole.
  function automatic logic [2:0] pick_code(input logic [7:0] value,
                                           input logic [2:0] prev);
    logic [2:0] idx;
    logic [2:0] code;
    idx  = 3'(value % 8'd5);
    code = code_at(idx);
    if (code == prev) begin
      code = code_at((idx == 3'd4) ? 3'd0 : idx + 3'd1);
    end
    return code;
  endfunction

  // Fibonacci feedback for x^8+x^6+x^5+x^4+1, shifted left into bit 0.
  always_comb begin
    lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  end

  // Candidate code, based on the LFSR value present in the transition cycle.
  always_comb begin
    spawn_code = pick_code(lfsr, prev_code);
  end

  // Next-state and next-output logic; pause holds everything and kills miss.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    lfsr_nxt      = lfsr;
    prev_code_nxt = prev_code;
    pos_nxt       = mole_pos;
    valid_nxt     = mole_valid;
    miss_nxt      = 1'b0;
    round_nxt     = round_count;

    if (!key_space) begin
      lfsr_nxt  = {lfsr[6:0], lfsr_fb};
      count_nxt = count + 32'd1;
      case (state)
        GAP: begin
          if (count == GAP_LAST) begin
            state_nxt     = UP;
            count_nxt     = 32'd0;
            pos_nxt       = spawn_code;
            valid_nxt     = 1'b1;
            prev_code_nxt = spawn_code;
            if (round_count != 8'hFF) begin
              round_nxt = round_count + 8'd1;
            end
          end
        end
        UP: begin
          if (hit) begin
            state_nxt = GAP;
            count_nxt = 32'd0;
            pos_nxt   = CODE_NONE;
            valid_nxt = 1'b0;
          end else if (count == UP_LAST) begin
            state_nxt = GAP;
            count_nxt = 32'd0;
            pos_nxt   = CODE_NONE;
            valid_nxt = 1'b0;
            miss_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = GAP;
          count_nxt = 32'd0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset from key_esc.
  always_ff @(posedge clk) begin
    if (key_esc) begin
      state       <= GAP;
      count       <= 32'd0;
      lfsr        <= LFSR_SEED;
      prev_code   <= CODE_NONE;
      mole_pos    <= CODE_NONE;
      mole_valid  <= 1'b0;
      miss_pulse  <= 1'b0;
      round_count <= 8'd0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      lfsr        <= lfsr_nxt;
      prev_code   <= prev_code_nxt;
      mole_pos    <= pos_nxt;
      mole_valid  <= valid_nxt;
      miss_pulse  <= miss_nxt;
      round_count <= round_nxt;
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Scoreboard bench for mole_spawner: stimulus updates a behavioural model and
// queues the expected outputs; a monitor compares them after each clock edge.
module tb_mole_spawner;

  localparam int UPC  = 4;
  localparam int GAPC = 2;
  localparam int SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       key_esc = 1'b1;
  logic       key_space = 1'b0;
  logic       hit = 1'b0;
  logic [2:0] mole_pos;
  logic       mole_valid;
  logic       miss_pulse;
  logic [7:0] round_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mole_spawner #(
    .UP_CYCLES (32'd4),
    .GAP_CYCLES(32'd2),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk        (clk),
    .key_esc    (key_esc),
    .key_space  (key_space),
    .hit        (hit),
    .mole_pos   (mole_pos),
    .mole_valid (mole_valid),
    .miss_pulse (miss_pulse),
    .round_count(round_count)
  );

  typedef struct {
    int pos;
    int miss;
    int rounds;
    bit rst;
  } exp_t;

  exp_t sb[$];

  // Reference model: tracks remaining cycles in the current phase.
  bit m_up;
  int m_left;
  int m_lfsr;
  int m_prev;
  int m_pos;
  int m_miss;
  int m_rounds;
  int m_spawns = 0;
  int tbl[5] = '{2, 1, 4, 5, 3};

  bit want_first = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lfsr_step(input int v);
    int fb;
    fb = $countones(v & 8'hB8) % 2;
    return ((v << 1) & 255) | fb;
  endfunction

  task automatic model_step(input bit esc, input bit sp, input bit h);
    int idx;
    int code;
    if (esc) begin
      m_up = 0; m_left = GAPC; m_lfsr = SEED; m_prev = 0;
      m_pos = 0; m_miss = 0; m_rounds = 0;
    end else if (sp) begin
      m_miss = 0;
    end else begin
      m_miss = 0;
      if (m_up) begin
        if (h) begin
          m_up = 0; m_left = GAPC; m_pos = 0;
        end else if (m_left == 1) begin
          m_up = 0; m_left = GAPC; m_pos = 0; m_miss = 1;
        end else begin
          m_left--;
        end
      end else begin
        if (m_left == 1) begin
          idx  = m_lfsr % 5;
          code = tbl[idx];
          if (code == m_prev) code = tbl[(idx + 1) % 5];
          m_prev = code; m_pos = code; m_up = 1; m_left = UPC;
          if (m_rounds < 255) m_rounds++;
          m_spawns++;
        end else begin
          m_left--;
        end
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  task automatic cycle(input bit esc, input bit sp, input bit h);
    exp_t e;
    @(negedge clk);
    key_esc = esc; key_space = sp; hit = h;
    model_step(esc, sp, h);
    e.pos = m_pos; e.miss = m_miss; e.rounds = m_rounds; e.rst = esc;
    sb.push_back(e);
  endtask

  task automatic wait_up(input int left);
    int n = 0;
    while (!(m_up && m_left == left) && n < 50) begin
      cycle(0, 0, 0);
      n++;
    end
    if (!(m_up && m_left == left)) check("wait_up_timeout", 0, 1);
  endtask

  // Monitor: compares DUT outputs against queued expectations.
  initial begin
    exp_t e;
    int last_code = 0;
    int seen_pos = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("mole_pos", int'(mole_pos), e.pos);
        check("mole_valid", int'(mole_valid), (e.pos != 0) ? 1 : 0);
        check("miss_pulse", int'(miss_pulse), e.miss);
        check("round_count", int'(round_count), e.rounds);
        check("legal_code", (mole_pos < 3'd6) ? 1 : 0, 1);
        if (e.rst) begin
          last_code = 0;
          seen_pos  = 0;
        end
        if (mole_pos != 3'd0 && seen_pos == 0) begin
          if (last_code != 0) check("consecutive_distinct", (int'(mole_pos) != last_code) ? 1 : 0, 1);
          if (want_first) begin
            check("first_code_after_reset", int'(mole_pos), 3);
            want_first = 1'b0;
          end
          last_code = int'(mole_pos);
        end
        seen_pos = int'(mole_pos);
      end
    end
  end

  initial begin
    int n;
    int target;
    bit sp;
    bit h;

    // Reset and idle run: gap, mole, expiry with miss.
    want_first = 1'b1;
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    repeat (10) cycle(0, 0, 0);
    check("first_code_seen", int'(want_first), 0);

    // Hit on the second visible cycle.
    wait_up(3);
    cycle(0, 0, 1);
    repeat (4) cycle(0, 0, 0);

    // Hit on the final visible cycle: no miss.
    wait_up(1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    repeat (3) cycle(0, 0, 0);

    // Pause mid-UP, including a hit that must be ignored.
    wait_up(3);
    repeat (5) cycle(0, 1, 0);
    cycle(0, 1, 1);
    repeat (4) cycle(0, 1, 0);
    repeat (8) cycle(0, 0, 0);

    // Randomized run until round_count saturates plus extra rounds.
    target = m_spawns + 300;
    n = 0;
    while (m_spawns < target && n < 20000) begin
      h  = ($urandom % 6) == 0;
      sp = ($urandom % 10) == 0;
      cycle(0, sp, h);
      n++;
    end
    check("random_run_done", (m_spawns >= target) ? 1 : 0, 1);
    @(negedge clk);
    check("round_saturated", int'(round_count), 255);
    sb.push_back('{pos: m_pos, miss: 0, rounds: m_rounds, rst: 1'b0});
    key_space = 1'b1;
    model_step(0, 1, 0);

    // Reset while a mole is up: discarded, no miss, first code repeats.
    wait_up(2);
    want_first = 1'b1;
    cycle(1, 0, 0);
    repeat (12) cycle(0, 0, 0);
    check("first_code_seen_2", int'(want_first), 0);

    // Reset during pause.
    wait_up(3);
    repeat (3) cycle(0, 1, 0);
    want_first = 1'b1;
    cycle(1, 1, 0);
    repeat (8) cycle(0, 0, 0);
    check("first_code_seen_3", int'(want_first), 0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
